// File: rtl/prog_loader.sv
// Boot/run controller: loads a length-prefixed big-endian byte stream into program
// memory while holding the core in reset, then runs it until halt or cycle limit.
module prog_loader #(
  parameter int          MEM_WORDS  = 64,
  parameter logic [31:0] HALT_INSN  = 32'hFC000000,
  parameter logic [31:0] MAX_CYCLES = 32'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] instruction,
  output logic [31:0] pmemaddr,
  output logic [31:0] pmemdata,
  output logic        pmemwe,
  output logic        cpustate,
  output logic        cpureset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        timeout,
  output logic [31:0] cycles
);

  localparam int KW = $clog2(MEM_WORDS + 1);

  typedef enum logic [2:0] {S_LEN, S_LOAD, S_START, S_RUN, S_HALT, S_ERROR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   sr_q, sr_d;       // first three bytes of the current length/word
  logic [KW-1:0] last_q, last_d;   // index of the final word (N-1)
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   word;
  logic [31:0]   pmemaddr_d, pmemdata_d, cycles_d;
  logic          pmemwe_d, cpustate_d, cpureset_d, timeout_d;
  logic          busy_d, done_d, error_d;

  assign word = {sr_q, rx_data};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sr_d       = sr_q;
    last_d     = last_q;
    k_d        = k_q;
    pmemaddr_d = pmemaddr;
    pmemdata_d = pmemdata;
    pmemwe_d   = 1'b0;
    cpustate_d = cpustate;
    cpureset_d = cpureset;
    timeout_d  = timeout;
    cycles_d   = cycles;

    unique case (state_q)
      S_LEN: begin
        if (rx_valid) begin
          sr_d       = word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word == 32'd0 || word > 32'(MEM_WORDS)) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_LOAD;
              last_d  = KW'(word - 32'd1);
              k_d     = '0;
            end
          end
        end
      end
      S_LOAD: begin
        if (rx_valid) begin
          sr_d       = word[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            pmemaddr_d = 32'({k_q, 2'b00});
            pmemdata_d = word;
            pmemwe_d   = 1'b1;
            if (k_q == last_q) state_d = S_START;
            else               k_d     = k_q + 1'b1;
          end
        end
      end
      S_START: begin
        state_d    = S_RUN;
        cpureset_d = 1'b0;
        cpustate_d = 1'b1;
        cycles_d   = '0;
      end
      S_RUN: begin
        // The exiting edge still counts: the core clocks once more on it.
        cycles_d = cycles + 32'd1;
        if (instruction == HALT_INSN) begin
          state_d    = S_HALT;
          cpustate_d = 1'b0;
        end else if (cycles == MAX_CYCLES - 32'd1) begin
          state_d    = S_HALT;
          cpustate_d = 1'b0;
          timeout_d  = 1'b1;
        end
      end
      S_HALT: begin
        if (rx_valid) begin
          state_d    = S_LEN;
          byte_cnt_d = 2'd1;
          sr_d       = word[23:0];
          cpureset_d = 1'b1;
          timeout_d  = 1'b0;
        end
      end
      S_ERROR: ;
      default: state_d = S_ERROR;
    endcase

    busy_d  = (state_d == S_LEN) || (state_d == S_LOAD) || (state_d == S_START);
    done_d  = (state_d == S_HALT);
    error_d = (state_d == S_ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_LEN;
      byte_cnt_q <= '0;
      sr_q       <= '0;
      last_q     <= '0;
      k_q        <= '0;
      pmemaddr   <= '0;
      pmemdata   <= '0;
      pmemwe     <= 1'b0;
      cpustate   <= 1'b0;
      cpureset   <= 1'b1;
      busy       <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      timeout    <= 1'b0;
      cycles     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      sr_q       <= sr_d;
      last_q     <= last_d;
      k_q        <= k_d;
      pmemaddr   <= pmemaddr_d;
      pmemdata   <= pmemdata_d;
      pmemwe     <= pmemwe_d;
      cpustate   <= cpustate_d;
      cpureset   <= cpureset_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      timeout    <= timeout_d;
      cycles     <= cycles_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: a small core model fetches from the written
// memory; expected writes and run outcomes are predicted from the sent program.
module tb_prog_loader;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] HALT      = 32'hFC000000;
  localparam int          MAXC      = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] instruction;
  logic [31:0] pmemaddr, pmemdata, cycles;
  logic        pmemwe, cpustate, cpureset, busy, done, error, timeout;

  prog_loader #(
    .MEM_WORDS (MEM_WORDS),
    .HALT_INSN (HALT),
    .MAX_CYCLES(32'(MAXC))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .instruction(instruction),
    .pmemaddr   (pmemaddr),
    .pmemdata   (pmemdata),
    .pmemwe     (pmemwe),
    .cpustate   (cpustate),
    .cpureset   (cpureset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .timeout    (timeout),
    .cycles     (cycles)
  );

  always #5 clk = ~clk;

  // Minimal core: program memory plus a pc that advances while running.
  logic [31:0] core_mem [MEM_WORDS];
  logic [5:0]  pc = '0;
  initial for (int i = 0; i < MEM_WORDS; i++) core_mem[i] = '0;
  always @(posedge clk) begin
    if (pmemwe) core_mem[pmemaddr[7:2]] <= pmemdata;
    if (cpureset)      pc <= '0;
    else if (cpustate) pc <= pc + 6'd1;
  end
  assign instruction = core_mem[pc];

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [31:0] cycles; logic timeout; } run_t;

  logic [31:0] model_mem [MEM_WORDS];
  initial for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = '0;
  wr_t         exp_wr[$];
  run_t        exp_run[$];
  logic [31:0] prog[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // The core runs from address 0 until the first halt word or the cycle limit.
  function automatic run_t predict_run();
    run_t r;
    r.cycles  = 32'(MAXC);
    r.timeout = 1'b1;
    for (int i = 0; i < MAXC; i++) begin
      if (model_mem[i] == HALT) begin
        r.cycles  = 32'(i + 1);
        r.timeout = 1'b0;
        break;
      end
    end
    return r;
  endfunction

  // Monitor: pops expected writes and run results as the DUT produces them.
  int   run_cnt = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (pmemwe) begin
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none expected", pmemaddr, pmemdata);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", pmemaddr, w.addr);
        check("wr_data", pmemdata, w.data);
      end
    end
    if (cpureset)      run_cnt = 0;
    else if (cpustate) run_cnt++;
    if (done && !done_prev) begin
      if (exp_run.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: cycles %0d, no run expected", cycles);
      end else begin
        run_t r;
        r = exp_run.pop_front();
        check("run_cycles", cycles, r.cycles);
        check("run_timeout", timeout, r.timeout);
        check("run_cpustate_high", run_cnt, r.cycles);
      end
    end
    done_prev = done;
  end

  // Caller is just after a rising edge; the byte is sampled on the next one.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pmemaddr"}, pmemaddr, 0);
    check({tag, "_pmemdata"}, pmemdata, 0);
    check({tag, "_pmemwe"},   pmemwe,   0);
    check({tag, "_cpustate"}, cpustate, 0);
    check({tag, "_cpureset"}, cpureset, 1);
    check({tag, "_busy"},     busy,     1);
    check({tag, "_done"},     done,     0);
    check({tag, "_error"},    error,    0);
    check({tag, "_timeout"},  timeout,  0);
    check({tag, "_cycles"},   cycles,   0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    check_reset_values(tag);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_program(input int gap);
    int          n;
    int          total;
    logic [31:0] w;
    logic        last_of_word;
    n     = prog.size();
    total = 4 + 4 * n;
    for (int i = 0; i < total; i++) begin
      w            = (i < 4) ? 32'(n) : prog[i / 4 - 1];
      last_of_word = (i >= 4) && (i % 4 == 3);
      if (last_of_word) begin
        exp_wr.push_back('{addr: 32'((i / 4 - 1) * 4), data: w});
        model_mem[i / 4 - 1] = w;
      end
      if (i == total - 1) exp_run.push_back(predict_run());
      send_byte(w[31 - 8 * (i % 4) -: 8]);
      check("pmemwe_after_byte", pmemwe, 32'(last_of_word));
      if (i == 0) begin
        check("first_byte_busy", busy, 1);
        check("first_byte_done", done, 0);
        check("first_byte_timeout", timeout, 0);
        check("first_byte_cpureset", cpureset, 1);
      end
      if (i < total - 1) begin
        repeat (gap) begin
          @(posedge clk); #1;
          check("pmemwe_idle", pmemwe, 0);
        end
      end
    end
    check("start_busy", busy, 1);
    check("start_cpustate", cpustate, 0);
    @(posedge clk); #1;
    check("run_cpustate", cpustate, 1);
    check("run_cpureset", cpureset, 0);
    check("run_busy", busy, 0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_halt_cpustate"}, cpustate, 0);
    check({tag, "_halt_cpureset"}, cpureset, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic error_case(input string tag, input logic [31:0] len);
    do_reset({tag, "_rst"});
    for (int i = 0; i < 4; i++) send_byte(len[31 - 8 * i -: 8]);
    check({tag, "_error"}, error, 1);
    check({tag, "_busy"}, busy, 0);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'($urandom));
      check({tag, "_no_write"}, pmemwe, 0);
      check({tag, "_cpustate"}, cpustate, 0);
    end
    check({tag, "_sticky"}, error, 1);
    check({tag, "_cpureset"}, cpureset, 1);
  endtask

  function automatic logic [31:0] rand_word(input bit allow_halt);
    logic [31:0] w;
    w = $urandom;
    if (allow_halt && $urandom_range(0, 3) == 0) w = HALT;
    else if (w == HALT) w = 32'h0;
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;
    @(posedge clk); #1;

    prog = '{32'h20010005, HALT};
    send_program(2);
    wait_done("slow");
    check("slow_cycles", cycles, 2);

    send_program(0);
    wait_done("b2b");
    check("b2b_cycles", cycles, 2);

    error_case("len0", 32'd0);
    error_case("len_over", 32'(MEM_WORDS + 1));
    do_reset("post_err");

    prog.delete();
    for (int i = 0; i < MAXC; i++) prog.push_back(rand_word(1'b0));
    send_program(1);
    wait_done("tmo");
    check("tmo_timeout", timeout, 1);
    check("tmo_cycles", cycles, 32'(MAXC));

    prog = '{HALT};
    send_program(0);
    wait_done("rerun");
    check("rerun_cycles", cycles, 1);

    // Reset partway through the second data word of a two-word program.
    prog = '{32'h11223344, 32'h55667788};
    for (int i = 0; i < 9; i++) begin
      logic [31:0] w;
      w = (i < 4) ? 32'd2 : prog[i / 4 - 1];
      if (i == 7) begin
        exp_wr.push_back('{addr: 32'd0, data: w});
        model_mem[0] = w;
      end
      send_byte(w[31 - 8 * (i % 4) -: 8]);
    end
    do_reset("midload");
    prog = '{rand_word(1'b0), HALT};
    send_program(0);
    wait_done("after_rst");

    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 12);
      prog.delete();
      for (int i = 0; i < n; i++) prog.push_back(rand_word(1'b1));
      send_program($urandom_range(0, 2));
      wait_done("rand");
    end

    check("wr_queue_drained", 32'(exp_wr.size()), 0);
    check("run_queue_drained", 32'(exp_run.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot and run controller for the single-cycle core. It receives a program as a byte stream, writes it word-by-word into program memory through the core's `pmemaddr`/`pmemdata`/`pmemwe` port, and holds the core in reset during loading. It then releases the core, drives `cpustate` high to run it, and stops it on a halt instruction or a cycle-limit timeout. It sits between the host byte receiver and the core top level.

## Interface
- `MEM_WORDS`, 64: program memory depth in 32-bit words; this is the maximum accepted program length.
- `HALT_INSN`, 32'hFC000000: instruction encoding that stops execution.
- `MAX_CYCLES`, 32'd1000000: run-cycle limit before a forced stop.

Ports:
- `clk` in 1: single clock. It is the same `clk` that drives the core and its program memory.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe per received byte. Strobes may arrive on back-to-back cycles.
- `rx_data` in 8: received byte, valid when `rx_valid`=1.
- `instruction` in 32: instruction currently fetched by the core.
- `pmemaddr` out 32: byte address for the program-memory write.
- `pmemdata` out 32: write data.
- `pmemwe` out 1: write enable, asserted for exactly one cycle per word.
- `cpustate` out 1: 1 runs the core (clock enabled), 0 stops it.
- `cpureset` out 1: reset to the core datapath, asserted while loading.
- `busy` out 1: high in states LEN, LOAD and START.
- `done` out 1: high in state HALT.
- `error` out 1: high in state ERROR.
- `timeout` out 1: set on a limit stop, cleared when a new load starts.
- `cycles` out 32: number of cycles the core ran with `cpustate`=1.

## Operation
- States are LEN, LOAD, START, RUN, HALT and ERROR. Reset enters LEN.
- **LEN**
  - Collects 4 bytes into length N, big-endian, first byte = bits 31:24.
  - Bytes are counted by a 2-bit byte counter.
  - On the 4th byte: N=0 or N>`MEM_WORDS` → ERROR; otherwise → LOAD with word index k=0.
- **LOAD**
  - Collects 4 bytes per word, big-endian, into a shift register.
  - On the 4th byte of word k, the edge registers `pmemaddr`=4·k, `pmemdata`=word and `pmemwe`=1. `pmemwe` falls on the next edge unless another word completes on that edge.
  - When k=N−1 → START; otherwise k increments and LOAD continues.
- **START**
  - Lasts one cycle; the final write pulse is active during it.
  - On exit: `cpureset`→0, `cpustate`→1, `cycles`→0, and the state moves to RUN.
- **RUN**
  - `cycles` increments on every edge while the state is RUN.
  - If `instruction`==`HALT_INSN` → HALT.
  - Otherwise, if `cycles`==`MAX_CYCLES`−1 → HALT with `timeout`=1.
  - Halt takes priority when both conditions hold on the same cycle; `timeout` then stays 0.
  - `rx_valid` is ignored in RUN.
- **HALT**
  - `cpustate`=0 and `cpureset`=0, so the core's state and `stdout` remain observable. `cycles` is held.
  - An `rx_valid` byte in HALT is taken as length byte 0 of a new load: → LEN with the byte counter at 1, `cpureset`=1, `timeout`=0, `done`=0.
- **ERROR**: sticky until `reset`; all `rx_valid` bytes are ignored. Outputs are `cpustate`=0 and `cpureset`=1.
- Bytes beyond N·4 cannot arrive while loading, since the state has already left LOAD.
- Length and word counters are wide enough for `MEM_WORDS`. Addresses are zero-extended to 32 bits.

## Timing
- All outputs are registered.
- Reset values:
  - `pmemaddr`=0, `pmemdata`=0, `pmemwe`=0
  - `cpustate`=0, `cpureset`=1
  - `busy`=1, `done`=0, `error`=0, `timeout`=0
  - `cycles`=0
- Write latency: a word's 4th byte seen in cycle t gives `pmemwe`=1 in cycle t+1 only.
- Last word: its 4th byte in cycle t gives `pmemwe`=1 with state START in t+1, then `cpustate`=1 and `cpureset`=0 in t+2.
- Halt latency: `HALT_INSN` seen in cycle c gives `cpustate`=0 in c+1. The core's clock edge at the end of cycle c still occurs, so `HALT_INSN` must be a datapath no-op.
- Timeout: `cpustate` is high for exactly `MAX_CYCLES` cycles, and `cycles` ends at `MAX_CYCLES`.
- Reset asserted mid-load or mid-run immediately returns the block to the reset values; partial words are discarded.

## Test plan
- Load N=2, words 0x20010005 and `HALT_INSN`, at one byte every 3 cycles → `pmemwe` pulses with addr 0/data 0x20010005 and addr 4/data 0xFC000000, then `cpustate`=1 two cycles after the last byte. HALT follows with `done`=1 and `cycles`=2.
- Same 12 bytes with `rx_valid` held high on consecutive cycles → two `pmemwe` pulses two... exactly 4 cycles apart, and the same end state.
- Length 0, and separately length `MEM_WORDS`+1 → `error`=1 one cycle after the 4th byte. Further bytes produce no `pmemwe`, and `cpustate` stays 0.
- Program with no halt and `MAX_CYCLES`=10 → `cpustate` is high for exactly 10 cycles, with `timeout`=1, `done`=1 and `cycles`=10.
- From HALT, send a new 8-byte program (N=1, word = `HALT_INSN`) → `done` and `timeout` clear on the first byte, `cpureset`=1, a write occurs to addr 0, and the core reruns.
- Assert `reset` after 5 of 8 data bytes → all outputs return to reset values at once. A fresh full load then writes from addr 0.
